// File: rtl/thirty_two_bits_divider.sv
// Restoring 32-bit DIV/DIVU: one subtract-and-shift step per clock, done 33 clocks after accept (1 for divide by zero).
// start is ignored while busy or while a divide-by-zero result is pending; results and flag hold until the next done.
module thirty_two_bits_divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        signed_op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        div_by_zero
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] q_q, q_d;
   logic [31:0] dvs_q, dvs_d;
   logic        q_neg_q, q_neg_d;
   logic        r_neg_q, r_neg_d;
   logic        zpend_q, zpend_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] quotient_q, quotient_d;
   logic [31:0] remainder_q, remainder_d;
   logic        dbz_q, dbz_d;
   logic [32:0] trial;
   logic [31:0] mag_a, mag_b;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      q_d         = q_q;
      dvs_d       = dvs_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      zpend_d     = zpend_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      mag_a       = (signed_op && dividend[31]) ? -dividend : dividend;
      mag_b       = (signed_op && divisor[31])  ? -divisor  : divisor;
      // rem never exceeds the divisor magnitude, so the accepted trial always has bit 32 clear
      trial       = {rem_q, q_q[31]} - {1'b0, dvs_q};

      case (state_q)
         IDLE: begin
            if (zpend_q) begin
               zpend_d     = 1'b0;
               quotient_d  = 32'hFFFF_FFFF;
               remainder_d = q_q;
               dbz_d       = 1'b1;
               done_d      = 1'b1;
            end else if (start) begin
               if (divisor == 32'd0) begin
                  zpend_d = 1'b1;
                  q_d     = dividend;
               end else begin
                  state_d = RUN;
                  busy_d  = 1'b1;
                  cnt_d   = 6'd0;
                  rem_d   = 32'd0;
                  q_d     = mag_a;
                  dvs_d   = mag_b;
                  q_neg_d = signed_op & (dividend[31] ^ divisor[31]);
                  r_neg_d = signed_op & dividend[31];
               end
            end
         end
         RUN: begin
            if (!trial[32]) begin
               rem_d = trial[31:0];
               q_d   = {q_q[30:0], 1'b1};
            end else begin
               rem_d = {rem_q[30:0], q_q[31]};
               q_d   = {q_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_d = FIX;
         end
         FIX: begin
            quotient_d  = q_neg_q ? -q_q : q_q;
            remainder_d = r_neg_q ? -rem_q : rem_q;
            dbz_d       = 1'b0;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 6'd0;
         rem_q       <= 32'd0;
         q_q         <= 32'd0;
         dvs_q       <= 32'd0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         zpend_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= 32'd0;
         remainder_q <= 32'd0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         q_q         <= q_d;
         dvs_q       <= dvs_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         zpend_q     <= zpend_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_thirty_two_bits_divider.sv
// Directed and randomized checks of the sequential divider against a plain-arithmetic reference.
module tb_thirty_two_bits_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        signed_op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int passed = 0;
   int total  = 0;

   logic        cur_s;
   logic [31:0] cur_a, cur_b;

   thirty_two_bits_divider dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .signed_op   (signed_op),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   // MIPS DIV/DIVU semantics: truncating division, remainder takes the dividend's sign.
   task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output logic z);
      int sa, sb;
      z = (b == 32'd0);
      if (z) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (!s) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else begin
         sa = a;
         sb = b;
         q  = sa / sb;
         r  = sa % sb;
      end
   endtask

   // Called at a negedge; returns just after the accept edge.
   task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
      cur_s     = s;
      cur_a     = a;
      cur_b     = b;
      signed_op = s;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      @(posedge clk);
   endtask

   // Waits for done (bounded) and checks latency, results and flag; returns at the negedge of the done cycle.
   task automatic finish(input int inject, input string tag);
      logic [31:0] eq, er;
      logic        ez;
      int          lat;
      logic        overlap;
      model(cur_s, cur_a, cur_b, eq, er, ez);
      @(negedge clk);
      start     = 1'b0;
      dividend  = $urandom;
      divisor   = $urandom;
      signed_op = 1'($urandom);
      check({tag, " busy_after_accept"}, {31'd0, busy}, {31'd0, !ez});
      lat     = 0;
      overlap = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (k == inject) begin
            start    = 1'b1;
            dividend = $urandom;
            divisor  = $urandom;
         end
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         if (busy && done) overlap = 1'b1;
         if (done) begin
            lat = k;
            break;
         end
      end
      check({tag, " latency"}, lat, ez ? 32'd1 : 32'd33);
      check({tag, " busy_done_overlap"}, {31'd0, overlap}, 32'd0);
      check({tag, " quotient"}, quotient, eq);
      check({tag, " remainder"}, remainder, er);
      check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, ez});
   endtask

   initial begin
      logic        seen;
      logic [31:0] a, b;
      logic        s;
      rst       = 1'b1;
      start     = 1'b0;
      signed_op = 1'b0;
      dividend  = 32'd0;
      divisor   = 32'd0;
      repeat (2) @(negedge clk);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset quotient", quotient, 32'd0);
      check("reset remainder", remainder, 32'd0);
      check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      launch(1'b0, 32'd100, 32'd7);
      finish(0, "divu_100_7");
      repeat (5) @(negedge clk);
      check("hold quotient", quotient, 32'd14);
      check("hold remainder", remainder, 32'd2);

      launch(1'b1, 32'hFFFF_FFF9, 32'd2);
      finish(0, "div_m7_2");
      launch(1'b1, 32'd7, 32'hFFFF_FFFE);
      finish(0, "div_7_m2");
      launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      finish(0, "div_overflow");
      launch(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      finish(0, "divu_8000_ffff");
      @(negedge clk);
      launch(1'b0, 32'h1234_5678, 32'd0);
      finish(0, "divu_by_zero");
      launch(1'b1, 32'd1000, 32'd10);
      finish(0, "clear_dbz");

      // start pulsed mid-operation must be ignored; then back-to-back accept in the done cycle
      launch(1'b0, 32'hDEAD_BEEF, 32'd12345);
      finish(10, "ignore_start_e10");
      launch(1'b1, 32'hCAFE_0001, 32'd77);
      finish(0, "back_to_back");

      launch(1'b0, 32'h0000_1000, 32'd3);
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort done", {31'd0, done}, 32'd0);
      check("abort quotient", quotient, 32'd0);
      check("abort remainder", remainder, 32'd0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("abort no_done", {31'd0, seen}, 32'd0);
      launch(1'b0, 32'hFFFF_FFFF, 32'h10);
      finish(0, "after_abort");

      for (int i = 0; i < 30; i++) begin
         s = 1'($urandom);
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 20));
            2:       b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 1) == 1) @(negedge clk);
         launch(s, a, b);
         finish((b != 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(2, 30)) : 0,
                $sformatf("rand%0d", i));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
